// File: rtl/onehot_cnt_pkg.sv
// Shared types and helpers for the one-hot event counter: line geometry,
// FSM state encoding and one-hot code classification.
package onehot_cnt_pkg;

    localparam int LINES = 4;
    localparam int IDX_W = 2;

    typedef enum logic {ST_RUN, ST_FROZEN} state_t;

    function automatic logic is_onehot(input logic [LINES-1:0] code);
        return $countones(code) == 1;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [LINES-1:0] code);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < LINES; k++)
            if (code[k]) idx = IDX_W'(k);
        return idx;
    endfunction

endpackage

// File: rtl/onehot_event_counter_if.sv
// Sample/read bus of the one-hot event counter. Optional encoder outputs
// appear only when ONEHOT_ENC_EN is defined.
interface onehot_event_counter_if #(parameter int CNT_W = 8);
    import onehot_cnt_pkg::*;

    logic [LINES-1:0] exp_i;
    logic             exp_vld_i;
    logic             clr_i;
    logic             rd_en_i;
    logic [IDX_W-1:0] rd_idx_i;
    logic [CNT_W-1:0] rd_data_o;
    logic             rd_vld_o;
    logic [LINES-1:0] sat_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             frozen_o;
`ifdef ONEHOT_ENC_EN
    logic [IDX_W-1:0] enc_o;
    logic             enc_vld_o;

    modport slave (
        input  exp_i, exp_vld_i, clr_i, rd_en_i, rd_idx_i,
        output rd_data_o, rd_vld_o, sat_o, err_o, err_cnt_o, frozen_o, enc_o, enc_vld_o
    );
    modport master (
        output exp_i, exp_vld_i, clr_i, rd_en_i, rd_idx_i,
        input  rd_data_o, rd_vld_o, sat_o, err_o, err_cnt_o, frozen_o, enc_o, enc_vld_o
    );
`else
    modport slave (
        input  exp_i, exp_vld_i, clr_i, rd_en_i, rd_idx_i,
        output rd_data_o, rd_vld_o, sat_o, err_o, err_cnt_o, frozen_o
    );
    modport master (
        output exp_i, exp_vld_i, clr_i, rd_en_i, rd_idx_i,
        input  rd_data_o, rd_vld_o, sat_o, err_o, err_cnt_o, frozen_o
    );
`endif

endinterface

// File: rtl/sat_counter.sv
// Unsigned saturating counter with synchronous clear and hold; never wraps.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !hold && !at_max)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/onehot_event_counter.sv
// Statistics/sanity monitor behind a 2-to-4 decoder: per-line saturating hit
// counts, illegal-code counting, indexed read. ONEHOT_ENC_EN adds enc_o/enc_vld_o.
module onehot_event_counter
    import onehot_cnt_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int SAT_FREEZE = 1
) (
    input logic                   clk_i,
    input logic                   reset_n,
    onehot_event_counter_if.slave bus
);

    localparam logic [CNT_W-1:0] NEAR_MAX = ~(CNT_W'(1));

    state_t                      state;
    logic                        take, code_ok, legal, illegal, hold;
    logic [LINES-1:0]            line_inc, line_max, line_hit;
    logic [LINES-1:0][CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0]            err_cnt;
    logic                        err_max, err_hit, reach_max;

    // clr wins over the sample presented in the same cycle
    assign take     = bus.exp_vld_i & ~bus.clr_i;
    assign code_ok  = is_onehot(bus.exp_i);
    assign legal    = take & code_ok;
    assign illegal  = take & ~code_ok;
    assign hold     = (state == ST_FROZEN);
    assign line_inc = legal ? bus.exp_i : '0;

    generate
        for (genvar k = 0; k < LINES; k++) begin : g_line
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk    (clk_i),
                .rst_n  (reset_n),
                .inc    (line_inc[k]),
                .clr    (bus.clr_i),
                .hold   (hold),
                .cnt    (line_cnt[k]),
                .at_max (line_max[k])
            );
            assign line_hit[k] = line_inc[k] & ~line_max[k] & (line_cnt[k] == NEAR_MAX);
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_err (
        .clk    (clk_i),
        .rst_n  (reset_n),
        .inc    (illegal),
        .clr    (bus.clr_i),
        .hold   (hold),
        .cnt    (err_cnt),
        .at_max (err_max)
    );
    assign err_hit = illegal & ~err_max & (err_cnt == NEAR_MAX);

    // Freeze is decided on the edge a counter hits max, so the very next
    // sample is already blocked; the error counter counts as "any counter".
    assign reach_max = (|line_hit) | err_hit;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n)
            state <= ST_RUN;
        else if (bus.clr_i)
            state <= ST_RUN;
        else if (state == ST_RUN && SAT_FREEZE != 0 && reach_max)
            state <= ST_FROZEN;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n)
            bus.err_o <= 1'b0;
        else if (bus.clr_i)
            bus.err_o <= 1'b0;
        else if (illegal)
            bus.err_o <= 1'b1;
    end

    // Read samples the pre-update counter, so a read colliding with clr
    // still returns the old value.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_vld_o  <= 1'b0;
            bus.rd_data_o <= '0;
        end else begin
            bus.rd_vld_o <= bus.rd_en_i;
            if (bus.rd_en_i)
                bus.rd_data_o <= line_cnt[bus.rd_idx_i];
        end
    end

`ifdef ONEHOT_ENC_EN
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            bus.enc_o     <= '0;
            bus.enc_vld_o <= 1'b0;
        end else begin
            bus.enc_vld_o <= legal;
            if (legal)
                bus.enc_o <= onehot_idx(bus.exp_i);
        end
    end
`endif

    assign bus.sat_o     = line_max;
    assign bus.err_cnt_o = err_cnt;
    assign bus.frozen_o  = hold;

endmodule
